// File: rtl/posit_extract_pipe.sv
// posit_extract_pipe: two-operand posit field extractor feeding exponent alignment.
// Two registered stages with valid/ready flow control; flags zero and NaR per operand.
// Ports:
//   Clk, nReset                 clock, async active-low reset
//   InValid/InReady             input handshake for the Posit1/Posit2 pair
//   Posit1, Posit2              raw N-bit operands
//   OutValid/OutReady           output handshake toward alignment
//   Sign*, InRemain*            sign and |posit| bits below the sign
//   RegimeValue*                signed regime k
//   Exponent*, Mantissa*        exponent field and {1, fraction, zero pad}
//   Zero*, NaR*                 special-value flags
module posit_extract_pipe #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [N-1:0]       Posit1,
    input  logic [N-1:0]       Posit2,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               Sign1,
    output logic               Sign2,
    output logic [N-2:0]       InRemain1,
    output logic [N-2:0]       InRemain2,
    output logic signed [RS:0] RegimeValue1,
    output logic signed [RS:0] RegimeValue2,
    output logic [ES-1:0]      Exponent1,
    output logic [ES-1:0]      Exponent2,
    output logic [N-ES+2:0]    Mantissa1,
    output logic [N-ES+2:0]    Mantissa2,
    output logic               Zero1,
    output logic               Zero2,
    output logic               NaR1,
    output logic               NaR2
);

    localparam int MW = N - ES + 3;
    localparam int FW = N - 1 - ES;

    // Length of the run of bits equal to the leading bit.
    function automatic logic [RS:0] lead_run(input logic [N-2:0] v);
        logic stop;
        lead_run = '0;
        stop = 1'b0;
        for (int b = N - 2; b >= 0; b--) begin
            if (!stop && (v[b] == v[N-2]))
                lead_run = lead_run + 1'b1;
            else
                stop = 1'b1;
        end
    endfunction

    logic w_in_fire;
    logic w_s2_load;

    logic [1:0][N-1:0] w_p;
    logic [1:0][N-2:0] w_mag;
    logic [1:0][RS:0]  w_run;
    logic [1:0]        w_zero;
    logic [1:0]        w_nar;

    logic              r_s1v;
    logic [1:0]        r_s1_sign;
    logic [1:0]        r_s1_zero;
    logic [1:0]        r_s1_nar;
    logic [1:0][N-2:0] r_s1_mag;
    logic [1:0][RS:0]  r_s1_run;

    logic [1:0][RS:0]   w_shamt;
    logic [1:0][N-2:0]  w_rem;
    logic [1:0][RS:0]   w_k;
    logic [1:0][ES-1:0] w_exp;
    logic [1:0][MW-1:0] w_man;

    logic               r_s2v;
    logic [1:0]         r_s2_sign;
    logic [1:0]         r_s2_zero;
    logic [1:0]         r_s2_nar;
    logic [1:0][N-2:0]  r_s2_mag;
    logic [1:0][RS:0]   r_s2_k;
    logic [1:0][ES-1:0] r_s2_exp;
    logic [1:0][MW-1:0] r_s2_man;

    assign InReady   = !r_s1v || !r_s2v || OutReady;
    assign w_in_fire = InValid && InReady;
    assign w_s2_load = r_s1v && (!r_s2v || OutReady);

    // Stage 1 combinational: sign, magnitude, specials, run length.
    // Only the low N-1 bits of -P are kept, so negate in that width.
    always_comb begin
        w_p[0] = Posit1;
        w_p[1] = Posit2;
        for (int i = 0; i < 2; i++) begin
            w_mag[i]  = w_p[i][N-1] ? (~w_p[i][N-2:0] + 1'b1)
                                    : w_p[i][N-2:0];
            w_zero[i] = (w_p[i] == '0);
            w_nar[i]  = (w_p[i] == {1'b1, {(N-1){1'b0}}});
            w_run[i]  = lead_run(w_mag[i]);
        end
    end

    // Stage 2 combinational: shifting out run + terminator leaves
    // exponent then fraction at the top; short tails pad with zeros.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_shamt[i] = r_s1_run[i] + 1'b1;
            w_rem[i]   = r_s1_mag[i] << w_shamt[i];
            w_k[i]     = r_s1_mag[i][N-2] ? (r_s1_run[i] - 1'b1)
                                          : (-r_s1_run[i]);
            w_exp[i]   = w_rem[i][N-2 -: ES];
            w_man[i]   = {1'b1, w_rem[i][FW-1:0], 3'b000};
            if (r_s1_zero[i] || r_s1_nar[i]) begin
                w_k[i]   = '0;
                w_exp[i] = '0;
                w_man[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_s1v     <= 1'b0;
            r_s1_sign <= '0;
            r_s1_zero <= '0;
            r_s1_nar  <= '0;
            r_s1_mag  <= '0;
            r_s1_run  <= '0;
        end else begin
            if (w_in_fire)
                r_s1v <= 1'b1;
            else if (w_s2_load)
                r_s1v <= 1'b0;
            if (w_in_fire) begin
                r_s1_sign <= {w_p[1][N-1], w_p[0][N-1]};
                r_s1_zero <= w_zero;
                r_s1_nar  <= w_nar;
                r_s1_mag  <= w_mag;
                r_s1_run  <= w_run;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_s2v     <= 1'b0;
            r_s2_sign <= '0;
            r_s2_zero <= '0;
            r_s2_nar  <= '0;
            r_s2_mag  <= '0;
            r_s2_k    <= '0;
            r_s2_exp  <= '0;
            r_s2_man  <= '0;
        end else begin
            if (w_s2_load)
                r_s2v <= 1'b1;
            else if (OutReady)
                r_s2v <= 1'b0;
            if (w_s2_load) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_nar  <= r_s1_nar;
                r_s2_mag  <= r_s1_mag;
                r_s2_k    <= w_k;
                r_s2_exp  <= w_exp;
                r_s2_man  <= w_man;
            end
        end
    end

    assign OutValid     = r_s2v;
    assign Sign1        = r_s2_sign[0];
    assign Sign2        = r_s2_sign[1];
    assign InRemain1    = r_s2_mag[0];
    assign InRemain2    = r_s2_mag[1];
    assign RegimeValue1 = r_s2_k[0];
    assign RegimeValue2 = r_s2_k[1];
    assign Exponent1    = r_s2_exp[0];
    assign Exponent2    = r_s2_exp[1];
    assign Mantissa1    = r_s2_man[0];
    assign Mantissa2    = r_s2_man[1];
    assign Zero1        = r_s2_zero[0];
    assign Zero2        = r_s2_zero[1];
    assign NaR1         = r_s2_nar[0];
    assign NaR2         = r_s2_nar[1];

endmodule
